// File: rtl/reorder_buffer.sv
// Reorder buffer: dual-slot in-order allocation, dual writeback, dual in-order
// retirement, and a partial flush that squashes everything younger than a given entry.
module reorder_buffer #(
    parameter int  NUM_ENTRIES   = 8,
    parameter int  NUM_REGISTERS = 32,
    parameter int  DATA_WIDTH    = 32,
    localparam int IDX_W         = $clog2(NUM_ENTRIES),
    localparam int REG_W         = $clog2(NUM_REGISTERS),
    localparam int CNT_W         = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc0,
    input  logic                  alloc1,
    input  logic [REG_W-1:0]      alloc_reg_addr0,
    input  logic [REG_W-1:0]      alloc_reg_addr1,
    output logic [IDX_W-1:0]      alloc_rob_addr0,
    output logic [IDX_W-1:0]      alloc_rob_addr1,
    output logic                  alloc_ready,
    input  logic                  wb0,
    input  logic                  wb1,
    input  logic [IDX_W-1:0]      wb_rob_addr0,
    input  logic [IDX_W-1:0]      wb_rob_addr1,
    input  logic [DATA_WIDTH-1:0] wb_data0,
    input  logic [DATA_WIDTH-1:0] wb_data1,
    input  logic                  flush,
    input  logic [IDX_W-1:0]      flush_rob_addr,
    output logic                  pop0,
    output logic                  pop1,
    output logic [REG_W-1:0]      pop_reg_addr0,
    output logic [REG_W-1:0]      pop_reg_addr1,
    output logic [IDX_W-1:0]      pop_rob_addr0,
    output logic [IDX_W-1:0]      pop_rob_addr1,
    output logic [DATA_WIDTH-1:0] pop_data0,
    output logic [DATA_WIDTH-1:0] pop_data1,
    output logic [IDX_W-1:0]      oldest,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full
);

    logic [IDX_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q;
    logic                  valid_q [NUM_ENTRIES];
    logic                  done_q  [NUM_ENTRIES];
    logic [REG_W-1:0]      reg_q   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] data_q  [NUM_ENTRIES];

    logic [IDX_W-1:0]       head_p1;
    logic                   accept0, accept1;
    logic                   flush_ok;
    logic [IDX_W-1:0]       flush_age;
    logic [CNT_W-1:0]       n_alloc, n_retire;
    logic [NUM_ENTRIES-1:0] squash, retire, alloc_sel0, alloc_sel1, wb_sel0, wb_sel1;

    // Pointer arithmetic, allocation acceptance, retirement and flush qualification.
    always_comb begin
        head_p1         = head_q + IDX_W'(1);
        alloc_ready     = (count_q <= CNT_W'(NUM_ENTRIES - 2));
        accept0         = alloc0 & alloc_ready & ~flush;
        accept1         = alloc1 & alloc_ready & ~flush;
        alloc_rob_addr0 = tail_q;
        alloc_rob_addr1 = alloc0 ? tail_q + IDX_W'(1) : tail_q;
        pop0            = valid_q[head_q] & done_q[head_q];
        pop1            = pop0 & valid_q[head_p1] & done_q[head_p1];
        // A flush naming an unoccupied entry is meaningless and is dropped.
        flush_ok        = flush & valid_q[flush_rob_addr];
        // Ages are offsets from head so wrap-around never confuses ordering.
        flush_age       = flush_rob_addr - head_q;
        n_alloc         = CNT_W'(accept0) + CNT_W'(accept1);
        n_retire        = CNT_W'(pop0) + CNT_W'(pop1);
    end

    // Per-entry update selects; wb0 takes priority over wb1 on the same entry.
    always_comb begin
        // NOTE: every vector gets a full default before the loop so no bit can hold its
        // old value, which would otherwise infer a latch.
        squash     = '0;
        retire     = '0;
        alloc_sel0 = '0;
        alloc_sel1 = '0;
        wb_sel0    = '0;
        wb_sel1    = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            squash[i]     = flush_ok && ((IDX_W'(i) - head_q) > flush_age);
            retire[i]     = (pop0 && IDX_W'(i) == head_q) || (pop1 && IDX_W'(i) == head_p1);
            alloc_sel0[i] = accept0 && IDX_W'(i) == alloc_rob_addr0;
            alloc_sel1[i] = accept1 && IDX_W'(i) == alloc_rob_addr1;
            wb_sel0[i]    = wb0 && wb_rob_addr0 == IDX_W'(i) && valid_q[i] && !done_q[i]
                            && !squash[i];
            wb_sel1[i]    = wb1 && wb_rob_addr1 == IDX_W'(i) && valid_q[i] && !done_q[i]
                            && !squash[i] && !wb_sel0[i];
        end
    end

    // Head, tail and occupancy; a flush rebuilds tail and count from the surviving age.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values,
            // so the order of these statements does not matter.
            head_q <= head_q + IDX_W'(pop0) + IDX_W'(pop1);
            if (flush_ok) begin
                tail_q  <= flush_rob_addr + IDX_W'(1);
                count_q <= CNT_W'(flush_age) + CNT_W'(1) - n_retire;
            end else begin
                tail_q  <= tail_q + IDX_W'(n_alloc);
                count_q <= count_q + n_alloc - n_retire;
            end
        end
    end

    // Entry storage: squash/retire clear, allocation opens, writeback completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: register and data storage is reset too, so the pop fields read as
            // zero after reset instead of stale contents.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
                reg_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (squash[i] || retire[i]) begin
                    valid_q[i] <= 1'b0;
                    done_q[i]  <= 1'b0;
                end else if (alloc_sel0[i]) begin
                    valid_q[i] <= 1'b1;
                    done_q[i]  <= 1'b0;
                    reg_q[i]   <= alloc_reg_addr0;
                end else if (alloc_sel1[i]) begin
                    valid_q[i] <= 1'b1;
                    done_q[i]  <= 1'b0;
                    reg_q[i]   <= alloc_reg_addr1;
                end else if (wb_sel0[i]) begin
                    done_q[i]  <= 1'b1;
                    data_q[i]  <= wb_data0;
                end else if (wb_sel1[i]) begin
                    done_q[i]  <= 1'b1;
                    data_q[i]  <= wb_data1;
                end
            end
        end
    end

    // Status and retirement fields; pop fields are valid only when qualified by pop0/pop1.
    always_comb begin
        oldest        = head_q;
        count         = count_q;
        empty         = (count_q == '0);
        full          = (count_q == CNT_W'(NUM_ENTRIES));
        pop_rob_addr0 = head_q;
        pop_rob_addr1 = head_p1;
        pop_reg_addr0 = reg_q[head_q];
        pop_reg_addr1 = reg_q[head_p1];
        pop_data0     = data_q[head_q];
        pop_data1     = data_q[head_p1];
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: allocation, writeback, in-order retirement,
// fill, wrap-around, flush, writeback collision and asynchronous reset.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc0, alloc1;
    logic [4:0]  alloc_reg_addr0, alloc_reg_addr1;
    logic [2:0]  alloc_rob_addr0, alloc_rob_addr1;
    logic        alloc_ready;
    logic        wb0, wb1;
    logic [2:0]  wb_rob_addr0, wb_rob_addr1;
    logic [31:0] wb_data0, wb_data1;
    logic        flush;
    logic [2:0]  flush_rob_addr;
    logic        pop0, pop1;
    logic [4:0]  pop_reg_addr0, pop_reg_addr1;
    logic [2:0]  pop_rob_addr0, pop_rob_addr1;
    logic [31:0] pop_data0, pop_data1;
    logic [2:0]  oldest;
    logic [3:0]  count;
    logic        empty, full;

    int n_checks = 0;
    int n_fail   = 0;

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .alloc0(alloc0), .alloc1(alloc1),
        .alloc_reg_addr0(alloc_reg_addr0), .alloc_reg_addr1(alloc_reg_addr1),
        .alloc_rob_addr0(alloc_rob_addr0), .alloc_rob_addr1(alloc_rob_addr1),
        .alloc_ready(alloc_ready),
        .wb0(wb0), .wb1(wb1),
        .wb_rob_addr0(wb_rob_addr0), .wb_rob_addr1(wb_rob_addr1),
        .wb_data0(wb_data0), .wb_data1(wb_data1),
        .flush(flush), .flush_rob_addr(flush_rob_addr),
        .pop0(pop0), .pop1(pop1),
        .pop_reg_addr0(pop_reg_addr0), .pop_reg_addr1(pop_reg_addr1),
        .pop_rob_addr0(pop_rob_addr0), .pop_rob_addr1(pop_rob_addr1),
        .pop_data0(pop_data0), .pop_data1(pop_data1),
        .oldest(oldest), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc0 = 1'b0; alloc1 = 1'b0; alloc_reg_addr0 = '0; alloc_reg_addr1 = '0;
        wb0 = 1'b0; wb1 = 1'b0; wb_rob_addr0 = '0; wb_rob_addr1 = '0;
        wb_data0 = '0; wb_data1 = '0; flush = 1'b0; flush_rob_addr = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic alloc_cycle(input logic a0, input logic [4:0] r0,
                               input logic a1, input logic [4:0] r1);
        alloc0 = a0; alloc_reg_addr0 = r0; alloc1 = a1; alloc_reg_addr1 = r1;
        tick();
        clear_inputs();
    endtask

    task automatic wb_cycle(input logic w0, input logic [2:0] i0, input logic [31:0] d0,
                            input logic w1, input logic [2:0] i1, input logic [31:0] d1);
        wb0 = w0; wb_rob_addr0 = i0; wb_data0 = d0;
        wb1 = w1; wb_rob_addr1 = i1; wb_data1 = d1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full); end
        n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %0b expected 1", alloc_ready); end
        n_checks++; if ({pop0, pop1} !== 2'b00) begin n_fail++; $display("FAIL reset_pop: got %b expected 00", {pop0, pop1}); end
        n_checks++; if (oldest !== 3'd0) begin n_fail++; $display("FAIL reset_oldest: got %0d expected 0", oldest); end
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (alloc_rob_addr0 !== 3'd0) begin n_fail++; $display("FAIL reset_addr0: got %0d expected 0", alloc_rob_addr0); end
        alloc0 = 1'b1;
        #1;
        n_checks++; if (alloc_rob_addr1 !== 3'd1) begin n_fail++; $display("FAIL reset_addr1: got %0d expected 1", alloc_rob_addr1); end
        tick();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_hold_alloc: got %0d expected 0", count); end
        clear_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_dual_alloc_retire();
        alloc0 = 1'b1; alloc_reg_addr0 = 5'd3; alloc1 = 1'b1; alloc_reg_addr1 = 5'd5;
        #1;
        n_checks++; if (alloc_rob_addr0 !== 3'd0) begin n_fail++; $display("FAIL dual_addr0: got %0d expected 0", alloc_rob_addr0); end
        n_checks++; if (alloc_rob_addr1 !== 3'd1) begin n_fail++; $display("FAIL dual_addr1: got %0d expected 1", alloc_rob_addr1); end
        tick();
        clear_inputs();
        n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL dual_count: got %0d expected 2", count); end
        wb_cycle(1'b1, 3'd1, 32'h11, 1'b0, 3'd0, 32'h0);
        n_checks++; if (pop0 !== 1'b0) begin n_fail++; $display("FAIL dual_out_of_order: got pop0=%0b expected 0", pop0); end
        wb1 = 1'b1; wb_rob_addr1 = 3'd0; wb_data1 = 32'h22;
        #1;
        n_checks++; if (pop0 !== 1'b0) begin n_fail++; $display("FAIL dual_no_bypass: got pop0=%0b expected 0", pop0); end
        tick();
        clear_inputs();
        n_checks++; if ({pop0, pop1} !== 2'b11) begin n_fail++; $display("FAIL dual_pops: got %b expected 11", {pop0, pop1}); end
        n_checks++; if (pop_reg_addr0 !== 5'd3 || pop_rob_addr0 !== 3'd0 || pop_data0 !== 32'h22) begin
            n_fail++; $display("FAIL dual_pop0_fields: got reg %0d idx %0d data %h expected 3 0 22", pop_reg_addr0, pop_rob_addr0, pop_data0); end
        n_checks++; if (pop_reg_addr1 !== 5'd5 || pop_rob_addr1 !== 3'd1 || pop_data1 !== 32'h11) begin
            n_fail++; $display("FAIL dual_pop1_fields: got reg %0d idx %0d data %h expected 5 1 11", pop_reg_addr1, pop_rob_addr1, pop_data1); end
        tick();
        n_checks++; if (count !== 4'd0 || empty !== 1'b1 || oldest !== 3'd2) begin
            n_fail++; $display("FAIL dual_drained: got count %0d empty %0b oldest %0d expected 0 1 2", count, empty, oldest); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            alloc_cycle(1'b1, 5'(2 * k), 1'b1, 5'(2 * k + 1));
            n_checks++; if (count !== 4'(2 * (k + 1))) begin
                n_fail++; $display("FAIL fill_count_%0d: got %0d expected %0d", k, count, 2 * (k + 1)); end
        end
        n_checks++; if (full !== 1'b1 || alloc_ready !== 1'b0 || alloc_rob_addr0 !== 3'd0) begin
            n_fail++; $display("FAIL fill_full: got full %0b ready %0b tail %0d expected 1 0 0", full, alloc_ready, alloc_rob_addr0); end
        alloc_cycle(1'b1, 5'd9, 1'b1, 5'd9);
        n_checks++; if (count !== 4'd8 || alloc_rob_addr0 !== 3'd0) begin
            n_fail++; $display("FAIL fill_extra_ignored: got count %0d tail %0d expected 8 0", count, alloc_rob_addr0); end
        wb_cycle(1'b1, 3'd0, 32'h5, 1'b0, 3'd0, 32'h0);
        n_checks++; if ({pop0, pop1} !== 2'b10) begin n_fail++; $display("FAIL fill_single_pop: got %b expected 10", {pop0, pop1}); end
        tick();
        n_checks++; if (count !== 4'd7 || alloc_ready !== 1'b0 || full !== 1'b0) begin
            n_fail++; $display("FAIL fill_count7: got count %0d ready %0b full %0b expected 7 0 0", count, alloc_ready, full); end
        alloc_cycle(1'b1, 5'd9, 1'b0, 5'd0);
        n_checks++; if (count !== 4'd7 || alloc_rob_addr0 !== 3'd0) begin
            n_fail++; $display("FAIL fill_count7_alloc: got count %0d tail %0d expected 7 0", count, alloc_rob_addr0); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 3; k++) alloc_cycle(1'b1, 5'd1, 1'b1, 5'd2);
        for (int k = 0; k < 3; k++) wb_cycle(1'b1, 3'(2 * k), 32'h0, 1'b1, 3'(2 * k + 1), 32'h0);
        tick();
        n_checks++; if (oldest !== 3'd6 || empty !== 1'b1) begin
            n_fail++; $display("FAIL wrap_head6: got oldest %0d empty %0b expected 6 1", oldest, empty); end
        alloc0 = 1'b1; alloc_reg_addr0 = 5'd10; alloc1 = 1'b1; alloc_reg_addr1 = 5'd11;
        #1;
        n_checks++; if (alloc_rob_addr0 !== 3'd6 || alloc_rob_addr1 !== 3'd7) begin
            n_fail++; $display("FAIL wrap_addrs: got %0d %0d expected 6 7", alloc_rob_addr0, alloc_rob_addr1); end
        tick();
        alloc1 = 1'b0; alloc_reg_addr0 = 5'd12;
        #1;
        n_checks++; if (alloc_rob_addr0 !== 3'd0) begin n_fail++; $display("FAIL wrap_addr0: got %0d expected 0", alloc_rob_addr0); end
        tick();
        clear_inputs();
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL wrap_count: got %0d expected 3", count); end
        wb_cycle(1'b1, 3'd7, 32'h77, 1'b1, 3'd0, 32'h100);
        n_checks++; if (pop0 !== 1'b0) begin n_fail++; $display("FAIL wrap_head_pending: got pop0=%0b expected 0", pop0); end
        wb_cycle(1'b1, 3'd6, 32'h66, 1'b0, 3'd0, 32'h0);
        n_checks++; if ({pop0, pop1} !== 2'b11 || pop_rob_addr0 !== 3'd6 || pop_data0 !== 32'h66 || pop_reg_addr0 !== 5'd10) begin
            n_fail++; $display("FAIL wrap_pop6: got pops %b idx %0d data %h reg %0d expected 11 6 66 10", {pop0, pop1}, pop_rob_addr0, pop_data0, pop_reg_addr0); end
        n_checks++; if (pop_rob_addr1 !== 3'd7 || pop_data1 !== 32'h77 || pop_reg_addr1 !== 5'd11) begin
            n_fail++; $display("FAIL wrap_pop7: got idx %0d data %h reg %0d expected 7 77 11", pop_rob_addr1, pop_data1, pop_reg_addr1); end
        tick();
        n_checks++; if ({pop0, pop1} !== 2'b10 || pop_rob_addr0 !== 3'd0 || pop_data0 !== 32'h100 || pop_reg_addr0 !== 5'd12) begin
            n_fail++; $display("FAIL wrap_pop0: got pops %b idx %0d data %h reg %0d expected 10 0 100 12", {pop0, pop1}, pop_rob_addr0, pop_data0, pop_reg_addr0); end
        tick();
        n_checks++; if (empty !== 1'b1 || oldest !== 3'd1) begin
            n_fail++; $display("FAIL wrap_drained: got empty %0b oldest %0d expected 1 1", empty, oldest); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_cycle(1'b1, 5'd20, 1'b1, 5'd21);
        alloc_cycle(1'b1, 5'd22, 1'b1, 5'd23);
        alloc_cycle(1'b1, 5'd24, 1'b0, 5'd0);
        flush = 1'b1; flush_rob_addr = 3'd2;
        wb0 = 1'b1; wb_rob_addr0 = 3'd4; wb_data0 = 32'h44;
        alloc0 = 1'b1; alloc_reg_addr0 = 5'd25;
        tick();
        clear_inputs();
        n_checks++; if (count !== 4'd3 || alloc_rob_addr0 !== 3'd3 || oldest !== 3'd0) begin
            n_fail++; $display("FAIL flush_state: got count %0d tail %0d oldest %0d expected 3 3 0", count, alloc_rob_addr0, oldest); end
        flush = 1'b1; flush_rob_addr = 3'd6; alloc0 = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (count !== 4'd3 || alloc_rob_addr0 !== 3'd3) begin
            n_fail++; $display("FAIL flush_invalid_ignored: got count %0d tail %0d expected 3 3", count, alloc_rob_addr0); end
        wb_cycle(1'b1, 3'd0, 32'hA0, 1'b1, 3'd1, 32'hA1);
        wb_cycle(1'b1, 3'd2, 32'hA2, 1'b1, 3'd4, 32'hA4);
        n_checks++; if ({pop0, pop1} !== 2'b10 || pop_rob_addr0 !== 3'd2 || pop_data0 !== 32'hA2 || pop_reg_addr0 !== 5'd22) begin
            n_fail++; $display("FAIL flush_last_pop: got pops %b idx %0d data %h reg %0d expected 10 2 a2 22", {pop0, pop1}, pop_rob_addr0, pop_data0, pop_reg_addr0); end
        tick();
        n_checks++; if (empty !== 1'b1 || count !== 4'd0 || pop0 !== 1'b0) begin
            n_fail++; $display("FAIL flush_drained: got empty %0b count %0d pop0 %0b expected 1 0 0", empty, count, pop0); end
        tick();
        n_checks++; if (pop0 !== 1'b0 || count !== 4'd0) begin
            n_fail++; $display("FAIL flush_no_squashed_pop: got pop0 %0b count %0d expected 0 0", pop0, count); end
    endtask

    task automatic test_wb_collision();
        do_reset();
        alloc_cycle(1'b1, 5'd30, 1'b1, 5'd31);
        alloc_cycle(1'b1, 5'd0, 1'b0, 5'd0);
        wb_cycle(1'b1, 3'd2, 32'hAAAA, 1'b1, 3'd2, 32'h5555);
        wb_cycle(1'b1, 3'd0, 32'h10, 1'b1, 3'd2, 32'h1234);
        n_checks++; if ({pop0, pop1} !== 2'b10) begin n_fail++; $display("FAIL coll_head_pop: got %b expected 10", {pop0, pop1}); end
        wb_cycle(1'b1, 3'd1, 32'h11, 1'b0, 3'd0, 32'h0);
        n_checks++; if ({pop0, pop1} !== 2'b11 || pop_rob_addr1 !== 3'd2 || pop_data1 !== 32'hAAAA) begin
            n_fail++; $display("FAIL coll_wb0_wins: got pops %b idx %0d data %h expected 11 2 aaaa", {pop0, pop1}, pop_rob_addr1, pop_data1); end
        tick();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL coll_drained: got empty %0b expected 1", empty); end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_cycle(1'b1, 5'd1, 1'b1, 5'd2);
        alloc_cycle(1'b1, 5'd3, 1'b1, 5'd4);
        alloc_cycle(1'b1, 5'd5, 1'b0, 5'd0);
        wb_cycle(1'b1, 3'd0, 32'h1, 1'b0, 3'd0, 32'h0);
        n_checks++; if (count !== 4'd5 || pop0 !== 1'b1) begin
            n_fail++; $display("FAIL areset_setup: got count %0d pop0 %0b expected 5 1", count, pop0); end
        #3;
        reset = 1'b0;
        #1;
        n_checks++; if (count !== 4'd0 || empty !== 1'b1 || pop0 !== 1'b0) begin
            n_fail++; $display("FAIL areset_immediate: got count %0d empty %0b pop0 %0b expected 0 1 0", count, empty, pop0); end
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (pop0 !== 1'b0 || count !== 4'd0 || alloc_rob_addr0 !== 3'd0) begin
            n_fail++; $display("FAIL areset_release: got pop0 %0b count %0d tail %0d expected 0 0 0", pop0, count, alloc_rob_addr0); end
    endtask

    initial begin
        test_reset();
        test_dual_alloc_retire();
        test_fill();
        test_wrap();
        test_flush();
        test_wb_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
